// File: rtl/run_det_pkg.sv
// -----------------------------------------------------------------------------
// run_det_pkg
// Shared definitions for the multi-channel run-length detector:
//   - phase_e     : per-channel run phase (IDLE / zero-run / one-run)
//   - LEN_MIN/MAX : legal range for the run-length parameters
//   - run_len()   : run length that asserts z for a given bit polarity
// -----------------------------------------------------------------------------
package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ZRUN = 2'b01,
    ORUN = 2'b10
  } phase_e;

  localparam int unsigned LEN_MIN = 32'd1;
  localparam int unsigned LEN_MAX = 32'd255;

  // Run length required for polarity b (0 -> zero_len, 1 -> one_len).
  function automatic int unsigned run_len(input logic        b,
                                          input int unsigned zero_len,
                                          input int unsigned one_len);
    if (b) begin
      return one_len;
    end else begin
      return zero_len;
    end
  endfunction

endpackage

// File: rtl/run_det_chan.sv
// -----------------------------------------------------------------------------
// run_det_chan
// One channel of the run-length detector. Tracks the current run polarity and
// its (saturating) length, and produces a Moore z/pol decode, a registered
// one-cycle hit pulse and a saturating hit counter.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear (beats in_valid)
//   in_valid in   sample strobe; 0 = bubble, state holds
//   w        in   serial data bit
//   z        out  run of the required length is in progress
//   pol      out  polarity of the current run (1 = ones)
//   hit      out  one-cycle pulse on the cycle z rises for a run
//   hit_cnt  out  saturating count of hits
// -----------------------------------------------------------------------------
module run_det_chan
  import run_det_pkg::*;
#(
  parameter int unsigned ZERO_LEN = 4,
  parameter int unsigned ONE_LEN  = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RW       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             w,
  output logic             z,
  output logic             pol,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  phase_e           phase_q, phase_d;
  logic [RW-1:0]    run_q, run_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cur_pol_s;
  logic             cur_z_s;
  logic             nxt_z_s;

  // Target length for a polarity, narrowed to the run counter width.
  function automatic logic [RW-1:0] len_of(input logic b);
    return RW'(run_len(b, ZERO_LEN, ONE_LEN));
  endfunction

  // State register: phase, run length, hit pulse and hit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= IDLE;
      run_q   <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      run_q   <= run_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: clear, bubble hold, or advance on a valid sample.
  always_comb begin
    phase_d = phase_q;
    run_d   = run_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    nxt_z_s = 1'b0;

    if (clr) begin
      phase_d = IDLE;
      run_d   = '0;
      hit_d   = 1'b0;
      cnt_d   = '0;
    end else if (in_valid) begin
      if ((phase_q == IDLE) || (w != cur_pol_s)) begin
        // New run starts with this bit.
        phase_d = w ? ORUN : ZRUN;
        run_d   = RW'(1);
      end else if (run_q >= len_of(w)) begin
        // Run already at target length: hold there instead of wrapping.
        run_d   = len_of(w);
      end else begin
        run_d   = run_q + RW'(1);
      end

      // Next phase is never IDLE here and its polarity is w.
      nxt_z_s = (run_d == len_of(w));
      // A polarity flip straight into a full run (length 1) is a new hit.
      hit_d   = nxt_z_s && (!cur_z_s || (w != cur_pol_s));

      if (hit_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      hit_d = 1'b0;
    end
  end

  // Output decode: Moore z/pol purely from the registered state.
  always_comb begin
    cur_pol_s = (phase_q == ORUN);
    cur_z_s   = (phase_q != IDLE) && (run_q == len_of(cur_pol_s));
  end

  assign z       = cur_z_s;
  assign pol     = cur_pol_s;
  assign hit     = hit_q;
  assign hit_cnt = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
// CH independent run-length detectors sharing clock, reset, clear and the
// sample strobe. Each channel asserts z while a run of ZERO_LEN zeros or
// ONE_LEN ones is in progress.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset
//   clr      in   synchronous clear of all channels and counters
//   in_valid in   sample strobe common to all channels
//   w        in   [CH]        serial data, bit i = channel i
//   z        out  [CH]        run detected
//   pol      out  [CH]        run polarity (1 = ones)
//   hit      out  [CH]        one-cycle pulse when z rises for a run
//   hit_cnt  out  [CH*CNT_W]  saturating hit counters, ch i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int unsigned CH       = 1,
  parameter int unsigned ZERO_LEN = 4,
  parameter int unsigned ONE_LEN  = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [CH-1:0]       w,
  output logic [CH-1:0]       z,
  output logic [CH-1:0]       pol,
  output logic [CH-1:0]       hit,
  output logic [CH*CNT_W-1:0] hit_cnt
);

  localparam int unsigned MAX_RUN = (ZERO_LEN > ONE_LEN) ? ZERO_LEN : ONE_LEN;
  // Run counter must hold the largest target length itself.
  localparam int unsigned RW      = $clog2(MAX_RUN + 1);

  if ((CH < 1) || (CNT_W < 1) ||
      (ZERO_LEN < LEN_MIN) || (ZERO_LEN > LEN_MAX) ||
      (ONE_LEN  < LEN_MIN) || (ONE_LEN  > LEN_MAX)) begin : g_bad_params
    $error("run_length_detector: illegal parameters CH=%0d CNT_W=%0d ZERO_LEN=%0d ONE_LEN=%0d",
           CH, CNT_W, ZERO_LEN, ONE_LEN);
  end

  for (genvar i = 0; i < CH; i++) begin : g_chan
    run_det_chan #(
      .ZERO_LEN (ZERO_LEN),
      .ONE_LEN  (ONE_LEN),
      .CNT_W    (CNT_W),
      .RW       (RW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (in_valid),
      .w        (w[i]),
      .z        (z[i]),
      .pol      (pol[i]),
      .hit      (hit[i]),
      .hit_cnt  (hit_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised, multi-channel Moore run-length detector. It is the next generation of the fixed four-zeros/four-ones sequence detector in the NPC sandbox. Each of CH independent serial inputs is tracked for a run of ZERO_LEN consecutive 0s or ONE_LEN consecutive 1s. Valid-qualified sampling lets idle cycles be skipped without breaking a run. Per-channel hit pulses and saturating hit counters are provided for the debug/perf path.

## Interface
- CH, 1, number of independent channels (≥1)
- ZERO_LEN, 4, consecutive-0 run length that asserts z (1..255)
- ONE_LEN, 4, consecutive-1 run length that asserts z (1..255)
- CNT_W, 8, width of each per-channel hit counter (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear of all channels and counters
- in_valid  in  1  sample strobe, common to all channels
- w  in  CH  serial data, bit i = channel i
- z  out  CH  run detected (Moore, decoded from state only)
- pol  out  CH  polarity of the current run (0 = zero-run, 1 = one-run)
- hit  out  CH  registered one-cycle pulse on the first cycle z rises for a run
- hit_cnt  out  CH*CNT_W  saturating hit counters, channel i at [i*CNT_W +: CNT_W]

## Operation
- Per-channel state is `{phase ∈ IDLE/ZRUN/ORUN, run[RW-1:0]}`, with `RW = $clog2(max(ZERO_LEN,ONE_LEN)+1)`.
- Reset (rst=0, async): phase=IDLE, run=0, hit=0, hit_cnt=0.
  - Consequences: z=0, pol=0.
- clr=1: same values as reset, applied at the next rising edge.
  - clr has priority over in_valid.
- in_valid=0: all state holds (bubble). z, pol, hit_cnt are unchanged; hit=0.
- in_valid=1, per channel, with L(b) = ZERO_LEN if b=0 else ONE_LEN:
  - phase=IDLE, or w differs from the current polarity: phase ← ZRUN/ORUN per w, run ← 1.
  - w equals the current polarity: run ← min(run+1, L(w)). The counter saturates and never wraps.
- z = (phase≠IDLE) && (run == L(pol)). z stays high while the run continues and drops on the first opposite bit.
- pol = 1 iff phase=ORUN.
- hit is set when the next-state z=1 and either the current z=0 or the polarity changes.
  - Example: with ZERO_LEN=1, a 0→1 flip into ONE_LEN=1 hits again.
  - Otherwise hit=0.
- hit_cnt[i] increments by 1 on the same edge that sets hit[i]. It saturates at 2^CNT_W−1.
- Length 1: a single bit of that polarity asserts z immediately after its sampling edge.
- Channels are fully independent apart from sharing clk, rst, clr and in_valid.

## Timing
- Single-cycle state update. w is sampled on the rising edge when in_valid=1.
- z, pol and hit reflect that sample right after the edge. No combinational path exists from w or in_valid to any output.
- Detection latency: z rises on the edge that samples the L-th consecutive valid bit of a run.
- z falls on the edge that samples the first opposite valid bit.
- hit is high for exactly one cycle per run, coincident with z's rising cycle.
- Reset deassertion mid-stream: the first valid sample after release starts a new run at run=1. No history survives reset.

## Structure
- Shared package `run_det_pkg` holds:
  - the phase enum (IDLE=2'b00, ZRUN=2'b01, ORUN=2'b10);
  - a length-select function returning L(b).
- Sub-module `run_det_chan`: one channel holding phase, run, hit and hit counter, instantiated CH times in a generate loop.
- The top level only fans out clk, rst, clr and in_valid, and packs the outputs.
- Parameter legality (lengths 1..255, CH≥1, CNT_W≥1) is checked at elaboration.

## Test plan
- Defaults, reset released, w=0 for 4 valid cycles:
  - z=0 after samples 1–3;
  - z=1 and hit=1 after sample 4;
  - hit=0 after sample 5 with z still 1;
  - hit_cnt=1.
- Defaults, w=1,1,1,0,1,1,1,1 all valid: z rises only after the 8th sample, pol=1, hit_cnt=1.
- in_valid toggling 1,0,1,0,1,0,1 with w=0 held: z rises on the 4th valid sample (cycle 7) and is unaffected by the bubbles.
- ZERO_LEN=2, ONE_LEN=5, CH=2:
  - ch0 w=0,0 → z[0]=1 after 2 samples;
  - ch1 w=1×5 → z[1]=1 after 5 samples;
  - no cross-channel effect.
- CNT_W=2, 5 separate zero-runs: hit_cnt saturates at 3. clr then zeroes hit_cnt, z and pol on the next edge.
- Assert rst low mid-run with run=3: z=0 and hit_cnt=0 immediately (async). After release, 3 more zeros do not assert z; a 4th does.
